// File: rtl/pcs_am_pkg.sv
// Shared definitions for 100GBASE-R alignment-marker insertion: block geometry,
// lane marker bytes and the scheduler state encoding.
package pcs_am_pkg;

   localparam int         LEN_CODED_BLOCK   = 66;
   localparam logic [1:0] AM_SYNC_HEADER    = 2'b10;
   localparam int         AM_PERIOD_DEFAULT = 16384;
   localparam int         NB_LANES          = 20;

   typedef struct packed {
      logic [7:0] m0;
      logic [7:0] m1;
      logic [7:0] m2;
   } am_marker_t;

   // Marker bytes M0..M2 per PCS lane; M4..M6 are their bitwise inverses.
   localparam am_marker_t AM_LANE_TABLE [NB_LANES] = '{
      '{8'hC1, 8'h68, 8'h21},
      '{8'h9D, 8'h71, 8'h8E},
      '{8'h59, 8'h4B, 8'hE8},
      '{8'h4D, 8'h95, 8'h7B},
      '{8'hF5, 8'h07, 8'h09},
      '{8'hDD, 8'h14, 8'hC2},
      '{8'h9A, 8'h4A, 8'h26},
      '{8'h7B, 8'h45, 8'h66},
      '{8'hA0, 8'h24, 8'h76},
      '{8'h68, 8'hC9, 8'hFB},
      '{8'hFD, 8'h6C, 8'h99},
      '{8'hB9, 8'h91, 8'h55},
      '{8'h5C, 8'hB9, 8'hB2},
      '{8'h1A, 8'hF8, 8'hBD},
      '{8'h83, 8'hC7, 8'hCA},
      '{8'h35, 8'h36, 8'hCD},
      '{8'hC4, 8'h31, 8'h4C},
      '{8'hAD, 8'hD6, 8'hB7},
      '{8'h5F, 8'h66, 8'h2A},
      '{8'hC0, 8'hF0, 8'hE5}
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AM   = 2'd1,
      DATA = 2'd2
   } am_state_t;

   // Out-of-range lane numbers fall back to lane 0.
   function automatic am_marker_t lane_marker(input logic [4:0] lane);
      if (lane < 5'(NB_LANES)) return AM_LANE_TABLE[lane];
      return AM_LANE_TABLE[0];
   endfunction

endpackage

// File: rtl/am_block_builder.sv
// Combinational packer for one 66b alignment-marker block:
// {sync, M0, M1, M2, BIP3, ~M0, ~M1, ~M2, ~BIP3}, M0 in bits [63:56].
module am_block_builder
   import pcs_am_pkg::*;
#(
   parameter logic [7:0] AM_M0 = 8'hC1,
   parameter logic [7:0] AM_M1 = 8'h68,
   parameter logic [7:0] AM_M2 = 8'h21
) (
   input  logic [7:0]                 bip3,
   output logic [LEN_CODED_BLOCK-1:0] am_block
);

   logic [7:0] bip7;

   assign bip7     = ~bip3;
   assign am_block = {AM_SYNC_HEADER,
                      AM_M0, AM_M1, AM_M2, bip3,
                      ~AM_M0, ~AM_M1, ~AM_M2, bip7};

endmodule

// File: rtl/am_insert_scheduler.sv
// Per-lane AM insertion scheduler: reserves one slot every AM_PERIOD blocks,
// stalls upstream for that slot and emits the marker carrying the closed period's BIP.
module am_insert_scheduler #(
   parameter int         LEN_CODED_BLOCK = pcs_am_pkg::LEN_CODED_BLOCK,
   parameter int         AM_PERIOD       = pcs_am_pkg::AM_PERIOD_DEFAULT,
   parameter int         NB_COUNT        = 14,
   parameter logic [7:0] AM_M0           = 8'hC1,
   parameter logic [7:0] AM_M1           = 8'h68,
   parameter logic [7:0] AM_M2           = 8'h21
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_enable,
   input  logic [LEN_CODED_BLOCK-1:0] i_data,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [7:0]                 i_bip3,
   output logic                       o_bip_enable,
   output logic                       o_am_insert,
   output logic [LEN_CODED_BLOCK-1:0] o_data,
   output logic                       o_valid,
   output logic                       o_am_flag
);

   import pcs_am_pkg::*;

   localparam logic [NB_COUNT-1:0] LAST_DATA = NB_COUNT'(AM_PERIOD - 1);

   am_state_t                  state_q,  state_d;
   logic [NB_COUNT-1:0]        count_q,  count_d;
   logic [LEN_CODED_BLOCK-1:0] data_q,   data_d;
   logic                       valid_q,  valid_d;
   logic                       am_q,     am_d;
   logic [LEN_CODED_BLOCK-1:0] am_block;
   logic                       transfer;

   am_block_builder #(
      .AM_M0 (AM_M0),
      .AM_M1 (AM_M1),
      .AM_M2 (AM_M2)
   ) u_am_block_builder (
      .bip3     (i_bip3),
      .am_block (am_block)
   );

   // Upstream may only move in DATA; the AM slot and a disabled lane both stall it.
   assign o_ready  = i_enable && (state_q == DATA);
   assign transfer = i_valid && o_ready;

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      data_d  = data_q;
      valid_d = 1'b0;
      am_d    = 1'b0;
      if (i_enable) begin
         unique case (state_q)
            IDLE: state_d = AM;
            AM: begin
               // The marker occupies slot 1 of the new period.
               data_d  = am_block;
               valid_d = 1'b1;
               am_d    = 1'b1;
               count_d = NB_COUNT'(1);
               state_d = DATA;
            end
            DATA: begin
               if (transfer) begin
                  data_d  = i_data;
                  valid_d = 1'b1;
                  if (count_q == LAST_DATA) begin
                     count_d = '0;
                     state_d = AM;
                  end else begin
                     count_d = count_q + NB_COUNT'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed above, independent of statement order.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         count_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         am_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         am_q    <= am_d;
      end
   end

   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_bip_enable = valid_q;
   assign o_am_flag    = am_q;
   assign o_am_insert  = am_q;

endmodule

// File: tb/tb_am_insert_scheduler.sv
// Directed bench for am_insert_scheduler with AM_PERIOD = 4, lane 0 markers.
module tb_am_insert_scheduler;

   logic        i_clock;
   logic        i_reset;
   logic        i_enable;
   logic [65:0] i_data;
   logic        i_valid;
   logic        o_ready;
   logic [7:0]  i_bip3;
   logic        o_bip_enable;
   logic        o_am_insert;
   logic [65:0] o_data;
   logic        o_valid;
   logic        o_am_flag;

   int n_checks = 0;
   int n_fail   = 0;

   am_insert_scheduler #(
      .LEN_CODED_BLOCK (66),
      .AM_PERIOD       (4),
      .NB_COUNT        (3),
      .AM_M0           (8'hC1),
      .AM_M1           (8'h68),
      .AM_M2           (8'h21)
   ) dut (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_enable     (i_enable),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_bip3       (i_bip3),
      .o_bip_enable (o_bip_enable),
      .o_am_insert  (o_am_insert),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .o_am_flag    (o_am_flag)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   typedef struct {
      logic        en;
      logic        vld;
      logic [65:0] data;
      logic [7:0]  bip3;
      logic        exp_ready;
      logic        exp_valid;
      logic        exp_am;
      logic [65:0] exp_data;
   } vec_t;

   vec_t vecs [10];

   function automatic logic [65:0] dblk(input int n);
      return {2'b01, 56'hDA7A0000000000, 8'(n)};
   endfunction

   // Lane 0 marker with the inverses written out by hand: ~C1=3E, ~68=97, ~21=DE.
   function automatic logic [65:0] am_exp(input logic [7:0] b);
      logic [7:0] nb;
      nb = ~b;
      return {2'b10, 8'hC1, 8'h68, 8'h21, b, 8'h3E, 8'h97, 8'hDE, nb};
   endfunction

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input string tag, input logic en, input logic vld,
                        input logic [65:0] d, input logic [7:0] b,
                        input logic e_rdy, input logic e_vld, input logic e_am,
                        input logic [65:0] e_data);
      @(negedge i_clock);
      i_enable = en;
      i_valid  = vld;
      i_data   = d;
      i_bip3   = b;
      #1 check({tag, " o_ready"}, 66'(o_ready), 66'(e_rdy));
      @(posedge i_clock);
      #1;
      check({tag, " o_valid"},      66'(o_valid),      66'(e_vld));
      check({tag, " o_bip_enable"}, 66'(o_bip_enable), 66'(e_vld));
      check({tag, " o_am_flag"},    66'(o_am_flag),    66'(e_am));
      check({tag, " o_am_insert"},  66'(o_am_insert),  66'(e_am));
      if (e_vld) check({tag, " o_data"}, o_data, e_data);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " o_data"},       o_data,             66'd0);
      check({tag, " o_valid"},      66'(o_valid),       66'd0);
      check({tag, " o_am_flag"},    66'(o_am_flag),     66'd0);
      check({tag, " o_am_insert"},  66'(o_am_insert),   66'd0);
      check({tag, " o_bip_enable"}, 66'(o_bip_enable),  66'd0);
      check({tag, " o_ready"},      66'(o_ready),       66'd0);
   endtask

   initial begin
      // Periodic stream: AM, D1..D3, AM(A5), D4..D6, AM with upstream idle.
      vecs[0] = '{1'b1, 1'b1, dblk(1), 8'h00, 1'b0, 1'b0, 1'b0, 66'd0};
      vecs[1] = '{1'b1, 1'b1, dblk(1), 8'h00, 1'b0, 1'b1, 1'b1, am_exp(8'h00)};
      vecs[2] = '{1'b1, 1'b1, dblk(1), 8'h11, 1'b1, 1'b1, 1'b0, dblk(1)};
      vecs[3] = '{1'b1, 1'b1, dblk(2), 8'h22, 1'b1, 1'b1, 1'b0, dblk(2)};
      vecs[4] = '{1'b1, 1'b1, dblk(3), 8'h33, 1'b1, 1'b1, 1'b0, dblk(3)};
      vecs[5] = '{1'b1, 1'b1, dblk(4), 8'hA5, 1'b0, 1'b1, 1'b1, am_exp(8'hA5)};
      vecs[6] = '{1'b1, 1'b1, dblk(4), 8'h00, 1'b1, 1'b1, 1'b0, dblk(4)};
      vecs[7] = '{1'b1, 1'b1, dblk(5), 8'h00, 1'b1, 1'b1, 1'b0, dblk(5)};
      vecs[8] = '{1'b1, 1'b1, dblk(6), 8'h00, 1'b1, 1'b1, 1'b0, dblk(6)};
      vecs[9] = '{1'b1, 1'b0, dblk(7), 8'h3C, 1'b0, 1'b1, 1'b1, am_exp(8'h3C)};

      i_reset  = 1'b1;
      i_enable = 1'b0;
      i_valid  = 1'b0;
      i_data   = '0;
      i_bip3   = '0;
      #2 check_all_zero("reset");
      @(negedge i_clock);
      i_reset = 1'b0;
      apply("idle_disabled", 1'b0, 1'b1, dblk(1), 8'h00, 1'b0, 1'b0, 1'b0, 66'd0);

      foreach (vecs[i])
         apply($sformatf("vec%0d", i), vecs[i].en, vecs[i].vld, vecs[i].data, vecs[i].bip3,
               vecs[i].exp_ready, vecs[i].exp_valid, vecs[i].exp_am, vecs[i].exp_data);

      // Upstream gaps do not consume slots: count is 1 after the AM above.
      apply("gap_d7", 1'b1, 1'b1, dblk(7), 8'h00, 1'b1, 1'b1, 1'b0, dblk(7));
      for (int g = 0; g < 3; g++)
         apply($sformatf("gap%0d", g), 1'b1, 1'b0, dblk(8), 8'h00, 1'b1, 1'b0, 1'b0, 66'd0);
      apply("gap_d8", 1'b1, 1'b1, dblk(8), 8'h00, 1'b1, 1'b1, 1'b0, dblk(8));
      apply("gap_d9", 1'b1, 1'b1, dblk(9), 8'h00, 1'b1, 1'b1, 1'b0, dblk(9));
      apply("gap_am", 1'b1, 1'b1, dblk(10), 8'h5E, 1'b0, 1'b1, 1'b1, am_exp(8'h5E));
      apply("gap_d10", 1'b1, 1'b1, dblk(10), 8'h00, 1'b1, 1'b1, 1'b0, dblk(10));

      // Freeze mid-period after the second data block, then resume.
      apply("frz_d11", 1'b1, 1'b1, dblk(11), 8'h00, 1'b1, 1'b1, 1'b0, dblk(11));
      for (int f = 0; f < 5; f++)
         apply($sformatf("frz%0d", f), 1'b0, 1'b1, dblk(12), 8'h77, 1'b0, 1'b0, 1'b0, 66'd0);
      apply("frz_d12", 1'b1, 1'b1, dblk(12), 8'h00, 1'b1, 1'b1, 1'b0, dblk(12));
      apply("frz_am",  1'b1, 1'b1, dblk(13), 8'h81, 1'b0, 1'b1, 1'b1, am_exp(8'h81));
      apply("frz_d13", 1'b1, 1'b1, dblk(13), 8'h00, 1'b1, 1'b1, 1'b0, dblk(13));

      // Asynchronous reset between edges, mid-period.
      #2 i_reset = 1'b1;
      #1 check_all_zero("midreset");
      i_reset = 1'b0;
      apply("rst_idle", 1'b1, 1'b1, dblk(14), 8'h00, 1'b0, 1'b0, 1'b0, 66'd0);
      apply("rst_am",   1'b1, 1'b1, dblk(14), 8'h00, 1'b0, 1'b1, 1'b1, am_exp(8'h00));
      apply("rst_d14",  1'b1, 1'b1, dblk(14), 8'h00, 1'b1, 1'b1, 1'b0, dblk(14));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
